fetch_control: RTL and testbench



---
 rtl/fetch_control.sv | 141 ++++++++++++++
 tb/tb_fetch_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// fetch_control: IF stage controller; drives PC select, imem req/ack, IF/ID with skid + redirect flush.
// Ports: clock/reset, PC in, PS out, imem_req/addr/ack/data, br_take/br_reg, stall, ifid_valid/instr/pc.
module fetch_control #(
  parameter int IW = 32,
  parameter int AW = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] PC,
  output logic [1:0]    PS,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic          br_take,
  input  logic          br_reg,
  input  logic          stall,
  output logic          ifid_valid,
  output logic [IW-1:0] ifid_instr,
  output logic [AW-1:0] ifid_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SKID,
    DROP
  } state_t;

  state_t state, nstate;

  logic [IW-1:0] skid_instr;
  logic [AW-1:0] skid_pc;
  logic [AW-1:0] drop_addr;

  logic accept;
  logic load_mem;
  logic load_skid;
  logic cap_skid;
  logic latch_drop;

  assign accept = !ifid_valid || !stall;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    case (state)
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = PC;
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    nstate     = state;
    PS         = 2'b00;
    load_mem   = 1'b0;
    load_skid  = 1'b0;
    cap_skid   = 1'b0;
    latch_drop = 1'b0;
    if (reset) begin
      nstate = IDLE;
    end else if (br_take) begin
      PS = br_reg ? 2'b01 : 2'b11;
      if (state == REQ && !imem_ack) begin
        // request still outstanding: wait it out at the old address
        nstate     = DROP;
        latch_drop = 1'b1;
      end else if (state == DROP) begin
        nstate = DROP;
      end else begin
        nstate = REQ;
      end
    end else begin
      case (state)
        IDLE: nstate = REQ;
        REQ: begin
          if (imem_ack) begin
            PS = 2'b10;
            if (accept) begin
              load_mem = 1'b1;
            end else begin
              cap_skid = 1'b1;
              nstate   = SKID;
            end
          end
        end
        SKID: begin
          if (!stall) begin
            load_skid = 1'b1;
            nstate    = REQ;
          end
        end
        DROP: begin
          if (imem_ack) nstate = REQ;
        end
        default: nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      drop_addr  <= '0;
    end else begin
      state <= nstate;
      if (load_mem) begin
        ifid_valid <= 1'b1;
        ifid_instr <= imem_data;
        ifid_pc    <= PC;
      end else if (load_skid) begin
        ifid_valid <= 1'b1;
        ifid_instr <= skid_instr;
        ifid_pc    <= skid_pc;
      end else if (br_take || !stall) begin
        ifid_valid <= 1'b0;
      end
      if (br_take) begin
        skid_instr <= '0;
        skid_pc    <= '0;
      end else if (cap_skid) begin
        skid_instr <= imem_data;
        skid_pc    <= PC;
      end
      if (latch_drop) drop_addr <= PC;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: directed bench for fetch_control with a PC model and a latency memory.
// Covers reset, streaming, stall/skid, redirects, DROP and reset in SKID/DROP.
module tb_fetch_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [1:0]  ps;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        br_take;
  logic        br_reg;
  logic        stall;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;

  logic [63:0] br_in;
  logic        ack_force;
  int          wait_n;
  int          cnt;
  int          total = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  fetch_control #(.IW(32), .AW(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .PC         (pc),
    .PS         (ps),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .br_take    (br_take),
    .br_reg     (br_reg),
    .stall      (stall),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc)
  );

  assign imem_ack  = ack_force || (imem_req && cnt == wait_n);
  assign imem_data = 32'hC0DE0000 | {16'h0, imem_addr[15:0]};

  always_ff @(posedge clock) begin
    if (reset || !imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always_ff @(posedge clock) begin
    if (reset) pc <= '0;
    else begin
      case (ps)
        2'b01: pc <= br_in;
        2'b10: pc <= pc + 64'd4;
        2'b11: pc <= pc + 64'd4 + (br_in << 2);
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_addr"}, imem_addr, 64'd0);
    chk({tag, "_ps"}, {62'd0, ps}, 64'd0);
    chk({tag, "_vld"}, {63'd0, ifid_valid}, 64'd0);
    chk({tag, "_ipc"}, ifid_pc, 64'd0);
    chk({tag, "_ins"}, {32'd0, ifid_instr}, 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; br_take = 1'b0; br_reg = 1'b0;
    br_in = '0; ack_force = 1'b0; wait_n = 0;
    tick(); tick(); #1;
    chk_reset("rst0");

    // zero-wait streaming, ack tied high
    reset = 1'b0; ack_force = 1'b1; #1;
    chk("c1_req", {63'd0, imem_req}, 64'd0);
    chk("c1_ps", {62'd0, ps}, 64'd0);
    tick(); #1;
    chk("c2_req", {63'd0, imem_req}, 64'd1);
    chk("c2_addr", imem_addr, 64'd0);
    chk("c2_ps", {62'd0, ps}, 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("str_vld", {63'd0, ifid_valid}, 64'd1);
      chk("str_ipc", ifid_pc, 64'(4 * i));
      chk("str_ps", {62'd0, ps}, 64'd2);
    end

    // stall 4 cycles: 12 goes to skid
    stall = 1'b1; #1;
    chk("stl_ps", {62'd0, ps}, 64'd2);
    chk("stl_addr", imem_addr, 64'd12);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("skid_req", {63'd0, imem_req}, 64'd0);
      chk("skid_ps", {62'd0, ps}, 64'd0);
      chk("skid_ipc", ifid_pc, 64'd8);
      chk("skid_vld", {63'd0, ifid_valid}, 64'd1);
    end
    tick(); stall = 1'b0; #1;
    chk("rel_ipc", ifid_pc, 64'd8);
    chk("rel_ps", {62'd0, ps}, 64'd0);
    tick(); #1;
    chk("rel1_ipc", ifid_pc, 64'd12);
    chk("rel1_ins", {32'd0, ifid_instr}, 64'hC0DE000C);
    chk("rel1_addr", imem_addr, 64'd16);
    chk("rel1_ps", {62'd0, ps}, 64'd2);
    tick(); #1;
    chk("rel2_ipc", ifid_pc, 64'd16);
    chk("rel2_ins", {32'd0, ifid_instr}, 64'hC0DE0010);
    chk("rel2_addr", imem_addr, 64'd20);

    // relative redirect while IF/ID valid: 20+4+16 = 40
    br_take = 1'b1; br_reg = 1'b0; br_in = 64'd4; #1;
    chk("brr_ps", {62'd0, ps}, 64'd3);
    tick(); br_take = 1'b0; #1;
    chk("brr_vld", {63'd0, ifid_valid}, 64'd0);
    chk("brr_addr", imem_addr, 64'h28);
    tick(); #1;
    chk("brr_ipc", ifid_pc, 64'h28);
    chk("brr_ins", {32'd0, ifid_instr}, 64'hC0DE0028);

    // 3-wait memory from a fresh reset
    reset = 1'b1; ack_force = 1'b0; wait_n = 3;
    tick(); reset = 1'b0; #1;
    chk("l1_req", {63'd0, imem_req}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("lw_req", {63'd0, imem_req}, 64'd1);
      chk("lw_addr", imem_addr, 64'd0);
      chk("lw_ps", {62'd0, ps}, 64'd0);
    end
    tick(); #1;
    chk("lack_ps", {62'd0, ps}, 64'd2);
    chk("lack_addr", imem_addr, 64'd0);
    tick(); #1;
    chk("l6_vld", {63'd0, ifid_valid}, 64'd1);
    chk("l6_ipc", ifid_pc, 64'd0);
    chk("l6_addr", imem_addr, 64'd4);
    chk("l6_ps", {62'd0, ps}, 64'd0);
    tick(); #1;
    chk("l7_drain", {63'd0, ifid_valid}, 64'd0);
    tick(); tick(); #1;
    chk("l9_ps", {62'd0, ps}, 64'd2);
    chk("l9_addr", imem_addr, 64'd4);
    tick(); #1;
    chk("l10_ipc", ifid_pc, 64'd4);
    chk("l10_vld", {63'd0, ifid_valid}, 64'd1);
    chk("l10_addr", imem_addr, 64'd8);
    tick(); tick();

    // absolute redirect on the ack cycle: data for 8 discarded
    tick(); br_take = 1'b1; br_reg = 1'b1; br_in = 64'h40; #1;
    chk("bra_ps", {62'd0, ps}, 64'd1);
    tick(); br_take = 1'b0; #1;
    chk("bra_vld", {63'd0, ifid_valid}, 64'd0);
    chk("bra_addr", imem_addr, 64'h40);

    // absolute redirect with request outstanding at 0x40
    tick(); br_take = 1'b1; br_reg = 1'b1; br_in = 64'h100; #1;
    chk("brd_ps", {62'd0, ps}, 64'd1);
    tick(); br_take = 1'b0; #1;
    chk("drop_req", {63'd0, imem_req}, 64'd1);
    chk("drop_addr", imem_addr, 64'h40);
    chk("drop_ps", {62'd0, ps}, 64'd0);
    tick(); #1;
    chk("dack_addr", imem_addr, 64'h40);
    chk("dack_ps", {62'd0, ps}, 64'd0);
    tick(); #1;
    chk("dnew_addr", imem_addr, 64'h100);
    chk("dnew_req", {63'd0, imem_req}, 64'd1);
    chk("dnew_vld", {63'd0, ifid_valid}, 64'd0);

    // reset while in DROP
    br_take = 1'b1; br_reg = 1'b1; br_in = 64'h200; #1;
    chk("brd2_ps", {62'd0, ps}, 64'd1);
    tick(); br_take = 1'b0; reset = 1'b1; #1;
    chk("drop2_addr", imem_addr, 64'h100);
    tick(); #1;
    chk_reset("rstd");

    // reset while in SKID
    reset = 1'b0; ack_force = 1'b1; #1;
    tick(); #1;
    chk("s2_ps", {62'd0, ps}, 64'd2);
    tick(); stall = 1'b1; #1;
    chk("s3_ipc", ifid_pc, 64'd0);
    chk("s3_ps", {62'd0, ps}, 64'd2);
    tick(); reset = 1'b1; #1;
    chk("s4_req", {63'd0, imem_req}, 64'd0);
    chk("s4_vld", {63'd0, ifid_valid}, 64'd1);
    tick(); #1;
    chk_reset("rsts");
    reset = 1'b0; stall = 1'b0; #1;
    tick(); #1;
    chk("sr2_addr", imem_addr, 64'd0);
    chk("sr2_ps", {62'd0, ps}, 64'd2);
    tick(); #1;
    chk("sr3_ipc", ifid_pc, 64'd0);
    chk("sr3_ins", {32'd0, ifid_instr}, 64'hC0DE0000);
    chk("sr3_vld", {63'd0, ifid_valid}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
